if_id_queue: RTL and testbench

Parametrised decoupling queue between instruction fetch and instruction decode. It replaces the single unstalled {pc, instruction} pipeline register with a DEPTH-entry FIFO that has valid/ready handshakes on both sides. A synchronous flush discards every queued entry on a control-flow redirect. Decode therefore sees a bubble-free stream when fetch runs ahead, and wrong-path instructions are removed on a taken branch or jump.

---
 rtl/if_id_queue.sv | 71 +++++++
 tb/tb_if_id_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling FIFO: DEPTH entries of {pc, instr}, valid/ready on both sides,
// and a synchronous flush that discards everything on a control-flow redirect.
module if_id_queue #(
    parameter int              XLEN      = 32,
    parameter int              ILEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [ILEN-1:0]          in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [ILEN-1:0]          out_instr,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    // Ready is a pure function of occupancy, so out_ready never reaches in_ready.
    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Storage is intentionally unreset; outputs are masked by occupancy instead.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign out_pc    = out_valid ? head.pc    : '0;
    assign out_instr = out_valid ? head.instr : NOP_INSTR;
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: a queue-based reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_if_id_queue;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_pc = '0, in_instr = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_pc, out_instr;
    logic        flush = 1'b0;
    logic [2:0]  count;

    int nchecks = 0;
    int nerrs   = 0;
    bit armed   = 1'b0;
    logic [63:0] mq[$];   // {pc, instr}, head at index 0

    if_id_queue #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .flush(flush), .count(count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model compare, every cycle away from the rising edge.
    always @(negedge i_clk) begin
        if (armed) begin
            chk("m_count", 64'(count), 64'(mq.size()));
            chk("m_in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
            chk("m_out_valid", 64'(out_valid), 64'(mq.size() != 0));
            chk("m_out_pc", 64'(out_pc), (mq.size() != 0) ? 64'(mq[0][63:32]) : 64'd0);
            chk("m_out_instr", 64'(out_instr), (mq.size() != 0) ? 64'(mq[0][31:0]) : 64'(NOP));
        end
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = 32'hA0 + (pc >> 2);
        out_ready = rdy;
        flush     = fl;
    endtask

    // One clock: model applies the queue rules at the edge, return at the falling edge.
    task automatic tick();
        bit pu, po;
        @(posedge i_clk);
        if (flush) begin
            mq.delete();
        end else begin
            pu = in_valid && (mq.size() < DEPTH);
            po = out_ready && (mq.size() != 0);
            if (po) void'(mq.pop_front());
            if (pu) mq.push_back({in_pc, in_instr});
        end
        @(negedge i_clk);
    endtask

    initial begin
        logic [31:0] exp_pop, next_push, hold_pc, hold_instr;

        // Reset
        drive(0, 0, 0, 0);
        repeat (2) @(negedge i_clk);
        i_rstn = 1'b1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'h13);
        armed = 1'b1;

        // Fill with decode stalled; fifth push must be ignored
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(i * 4), 0, 0);
            tick();
            chk("fill_out_pc", 64'(out_pc), 64'h0);
        end
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        drive(1, 32'h10, 0, 0);
        tick();
        chk("full_count", 64'(count), 64'd4);
        chk("full_out_pc", 64'(out_pc), 64'h0);
        chk("full_out_instr", 64'(out_instr), 64'hA0);

        // Alternate pop/push across pointer wrap
        exp_pop = 32'h0;
        next_push = 32'h10;
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) begin
                drive(0, 0, 1, 0);
                chk("drain_order", 64'(out_pc), 64'(exp_pop));
                exp_pop += 4;
                tick();
                chk("drain_count3", 64'(count), 64'd3);
            end else begin
                drive(1, next_push, 0, 0);
                next_push += 4;
                tick();
                chk("drain_count4", 64'(count), 64'd4);
            end
        end
        chk("wrap_head", 64'(out_pc), 64'h14);

        // Simultaneous push and pop at count 2
        drive(0, 0, 1, 0);
        tick();
        tick();
        chk("c2_count", 64'(count), 64'd2);
        chk("c2_head", 64'(out_pc), 64'h1C);
        drive(1, 32'h24, 1, 0);
        tick();
        chk("pp_count", 64'(count), 64'd2);
        chk("pp_head", 64'(out_pc), 64'h20);
        drive(0, 0, 1, 0);
        tick();
        chk("pp_new_head", 64'(out_pc), 64'h24);
        chk("pp_new_instr", 64'(out_instr), 64'hA9);
        tick();
        chk("empty_instr", 64'(out_instr), 64'h13);
        chk("empty_valid", 64'(out_valid), 64'd0);

        // Flush mid-stream with a push and pop in the same cycle
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h30 + 32'(i * 4), 0, 0);
            tick();
        end
        chk("pre_flush_count", 64'(count), 64'd3);
        drive(1, 32'h40, 1, 1);
        tick();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        drive(1, 32'h80, 0, 0);
        tick();
        chk("post_flush_head", 64'(out_pc), 64'h80);
        chk("post_flush_count", 64'(count), 64'd1);
        drive(0, 0, 0, 1);
        tick();
        tick();
        chk("flush_empty_count", 64'(count), 64'd0);
        chk("flush_empty_pc", 64'(out_pc), 64'd0);

        // Backpressure stability
        drive(0, 0, 0, 0);
        tick();
        drive(1, 32'h100, 0, 0);
        tick();
        drive(1, 32'h104, 0, 0);
        tick();
        chk("bp_count", 64'(count), 64'd2);
        hold_pc = out_pc;
        hold_instr = out_instr;
        chk("bp_head", 64'(hold_pc), 64'h100);
        drive(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_pc", 64'(out_pc), 64'(hold_pc));
            chk("bp_hold_instr", 64'(out_instr), 64'(hold_instr));
        end
        drive(0, 0, 1, 0);
        tick();
        chk("bp_pop1", 64'(out_pc), 64'h104);
        chk("bp_pop1_count", 64'(count), 64'd1);
        tick();
        chk("bp_pop2_count", 64'(count), 64'd0);

        // Asynchronous reset mid-operation
        drive(1, 32'h200, 0, 0);
        tick();
        drive(1, 32'h204, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        #2 i_rstn = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_instr", 64'(out_instr), 64'h13);
        mq.delete();
        #1 i_rstn = 1'b1;
        @(negedge i_clk);
        drive(1, 32'h300, 0, 0);
        tick();
        chk("arst_push", 64'(out_pc), 64'h300);
        drive(0, 0, 1, 0);
        tick();
        tick();

        armed = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end
endmodule
